// File: rtl/cpu_decode_stage.sv
// RV32I decode stage: splits fields, classifies format, sign-extends the immediate.
// One-cycle latency; optional two-entry skid keeps full throughput with a registered o_ready.
module cpu_decode_stage #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instruction,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [PC_W-1:0] o_pc,
  output logic [6:0]      o_opcode,
  output logic [2:0]      o_funct3,
  output logic [6:0]      o_funct7,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [2:0]      o_fmt,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  function automatic payload_t decode(input logic [31:0] inst, input logic [PC_W-1:0] pc);
    payload_t          p;
    logic signed [31:0] imm32;
    p        = '0;
    imm32    = '0;
    p.pc     = pc;
    p.opcode = inst[6:0];
    p.funct3 = inst[14:12];
    p.funct7 = inst[31:25];
    p.rs1    = inst[19:15];
    p.rs2    = inst[24:20];
    p.rd     = inst[11:7];
    case (inst[6:0])
      7'b0110011: p.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
        p.fmt = FMT_I;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0100011: begin
        p.fmt = FMT_S;
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b1100011: begin
        p.fmt = FMT_B;
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        p.fmt = FMT_U;
        imm32 = {inst[31:12], 12'b0};
      end
      7'b1101111: begin
        p.fmt = FMT_J;
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: begin
        p.fmt     = FMT_ILL;
        p.illegal = 1'b1;
      end
    endcase
    // Every 32-bit form already carries its sign in bit 31, so widening is a plain sign-extend.
    p.imm = XLEN'(imm32);
    return p;
  endfunction

  state_t   state_q;
  payload_t out_q;
  payload_t skid_q;
  payload_t dec_d;
  logic     in_xfer;
  logic     out_xfer;

  assign dec_d    = decode(i_instruction, i_pc);
  assign o_valid  = (state_q != ST_EMPTY);
  assign o_ready  = SKID_EN ? (state_q != ST_SKID) : (!o_valid || i_ready);
  assign in_xfer  = i_valid && o_ready;
  assign out_xfer = o_valid && i_ready;

  // Without the skid, o_ready in FULL implies i_ready, so the SKID branch is unreachable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else if (i_flush) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            out_q   <= dec_d;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            out_q <= dec_d;
          end else if (in_xfer) begin
            skid_q  <= dec_d;
            state_q <= ST_SKID;
          end else if (out_xfer) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            out_q   <= skid_q;
            state_q <= ST_FULL;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign o_pc      = out_q.pc;
  assign o_opcode  = out_q.opcode;
  assign o_funct3  = out_q.funct3;
  assign o_funct7  = out_q.funct7;
  assign o_rs1     = out_q.rs1;
  assign o_rs2     = out_q.rs2;
  assign o_rd      = out_q.rd;
  assign o_fmt     = out_q.fmt;
  assign o_imm     = out_q.imm;
  assign o_illegal = out_q.illegal;

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Bench for cpu_decode_stage: directed scenarios plus a randomized run against a queue model.
module tb_cpu_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [31:0] i_instruction = '0;
  logic [31:0] i_pc = '0;
  logic        o_ready, o_valid, o_illegal;
  logic [31:0] o_pc, o_imm;
  logic [6:0]  o_opcode, o_funct7;
  logic [2:0]  o_funct3, o_fmt;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  exp_t        obs;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t q[$];

  cpu_decode_stage #(.XLEN(32), .PC_W(32), .SKID_EN(1'b1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_instruction(i_instruction), .i_pc(i_pc),
    .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_opcode(o_opcode),
    .o_funct3(o_funct3), .o_funct7(o_funct7), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
    .o_fmt(o_fmt), .o_imm(o_imm), .o_illegal(o_illegal)
  );

  assign obs = {o_pc, o_opcode, o_funct3, o_funct7, o_rs1, o_rs2, o_rd, o_fmt, o_imm, o_illegal};

  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference decode built from the immediate bit-position rules with shifts and masks.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    logic signed [31:0] sw;
    logic [31:0] sx;
    sw = w;
    sx = {32{w[31]}};
    e.pc = pc; e.op = w[6:0]; e.f3 = w[14:12]; e.f7 = w[31:25];
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    e.ill = 1'b0; e.imm = '0; e.fmt = 3'd7;
    case (w[6:0])
      7'h33: e.fmt = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin e.fmt = 3'd1; e.imm = sw >>> 20; end
      7'h23: begin
        e.fmt = 3'd2;
        e.imm = (sx << 11) | (32'(w[30:25]) << 5) | 32'(w[11:7]);
      end
      7'h63: begin
        e.fmt = 3'd3;
        e.imm = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      end
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = w & 32'hFFFF_F000; end
      7'h6F: begin
        e.fmt = 3'd5;
        e.imm = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      end
      default: begin e.fmt = 3'd7; e.ill = 1'b1; e.imm = '0; end
    endcase
    return e;
  endfunction

  task automatic cyc(input logic v, input logic [31:0] w, input logic [31:0] pc,
                     input logic rdy, input logic fl);
    @(negedge i_clk);
    i_valid = v; i_instruction = w; i_pc = pc; i_ready = rdy; i_flush = fl;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_in_reset: got %b expected 0", o_valid); end
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    n_tests++;
    if ({o_valid, o_ready} !== 2'b01) begin n_fail++; $display("FAIL reset_valid_ready: got %b expected 01", {o_valid, o_ready}); end
    n_tests++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs); end
  endtask

  task automatic test_single;
    cyc(1'b1, 32'hFFF0_0093, 32'h100, 1'b1, 1'b0);
    n_tests++;
    if ({o_valid, o_opcode, o_rd, o_rs1, o_fmt, o_imm, o_pc, o_illegal} !==
        {1'b1, 7'h13, 5'd1, 5'd0, 3'd1, 32'hFFFF_FFFF, 32'h100, 1'b0}) begin
      n_fail++;
      $display("FAIL single_addi: got v=%b op=%h rd=%0d rs1=%0d fmt=%0d imm=%h pc=%h ill=%b",
               o_valid, o_opcode, o_rd, o_rs1, o_fmt, o_imm, o_pc, o_illegal);
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got valid %b expected 0", o_valid); end
  endtask

  task automatic test_formats;
    logic [31:0] insts [4];
    logic [2:0]  fmts  [4];
    logic [31:0] imms  [4];
    insts = '{32'h0020_A423, 32'hFE00_0EE3, 32'h1234_52B7, 32'h0010_00EF};
    fmts  = '{3'd2, 3'd3, 3'd4, 3'd5};
    imms  = '{32'h8, 32'hFFFF_FFFC, 32'h1234_5000, 32'h800};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, insts[i], 32'h200 + 32'(i * 4), 1'b1, 1'b0);
      n_tests++;
      if ({o_valid, o_fmt, o_imm} !== {1'b1, fmts[i], imms[i]}) begin
        n_fail++;
        $display("FAIL format_%0d: got v=%b fmt=%0d imm=%h expected fmt=%0d imm=%h",
                 i, o_valid, o_fmt, o_imm, fmts[i], imms[i]);
      end
      n_tests++;
      if (obs !== ref_decode(insts[i], 32'h200 + 32'(i * 4))) begin
        n_fail++;
        $display("FAIL format_fields_%0d: got %h expected %h", i, obs, ref_decode(insts[i], 32'h200 + 32'(i * 4)));
      end
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure;
    exp_t ea, eb, ec;
    ea = ref_decode(32'h0010_0093, 32'h300);
    eb = ref_decode(32'h0020_0113, 32'h304);
    ec = ref_decode(32'h0030_0193, 32'h308);
    cyc(1'b1, 32'h0010_0093, 32'h300, 1'b0, 1'b0);
    n_tests++;
    if ({o_valid, o_ready, obs} !== {1'b1, 1'b1, ea}) begin n_fail++; $display("FAIL bp_first: got v=%b r=%b %h expected v=1 r=1 %h", o_valid, o_ready, obs, ea); end
    cyc(1'b1, 32'h0020_0113, 32'h304, 1'b0, 1'b0);
    n_tests++;
    if ({o_ready, obs} !== {1'b0, ea}) begin n_fail++; $display("FAIL bp_second: got r=%b %h expected r=0 %h", o_ready, obs, ea); end
    cyc(1'b1, 32'h0030_0193, 32'h308, 1'b0, 1'b0);
    n_tests++;
    if ({o_ready, obs} !== {1'b0, ea}) begin n_fail++; $display("FAIL bp_hold: got r=%b %h expected r=0 %h", o_ready, obs, ea); end
    cyc(1'b1, 32'h0030_0193, 32'h308, 1'b1, 1'b0);
    n_tests++;
    if ({o_valid, o_ready, obs} !== {1'b1, 1'b1, eb}) begin n_fail++; $display("FAIL bp_drain_b: got v=%b r=%b %h expected %h", o_valid, o_ready, obs, eb); end
    cyc(1'b1, 32'h0030_0193, 32'h308, 1'b1, 1'b0);
    n_tests++;
    if ({o_valid, obs} !== {1'b1, ec}) begin n_fail++; $display("FAIL bp_drain_c: got v=%b %h expected %h", o_valid, obs, ec); end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got valid %b expected 0", o_valid); end
  endtask

  task automatic test_illegal;
    cyc(1'b1, 32'h0, 32'h400, 1'b1, 1'b0);
    n_tests++;
    if ({o_valid, o_illegal, o_fmt, o_imm} !== {1'b1, 1'b1, 3'd7, 32'h0}) begin
      n_fail++;
      $display("FAIL illegal_zero: got v=%b ill=%b fmt=%0d imm=%h expected 1 1 7 0", o_valid, o_illegal, o_fmt, o_imm);
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_flush;
    cyc(1'b1, 32'h0010_0093, 32'h500, 1'b0, 1'b0);
    cyc(1'b1, 32'h0020_0113, 32'h504, 1'b0, 1'b0);
    n_tests++;
    if (o_ready !== 1'b0) begin n_fail++; $display("FAIL flush_setup_skid: got ready %b expected 0", o_ready); end
    cyc(1'b1, 32'h0030_0193, 32'h508, 1'b0, 1'b1);
    n_tests++;
    if ({o_valid, o_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_result: got v/r %b expected 01", {o_valid, o_ready}); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n_tests++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_leak_%0d: got valid %b expected 0", i, o_valid); end
    end
  endtask

  task automatic test_async_reset;
    cyc(1'b1, 32'hFFF0_0093, 32'h600, 1'b0, 1'b0);
    n_tests++;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL areset_setup: got valid %b expected 1", o_valid); end
    #2;
    i_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_valid, obs} !== {1'b0, 100'h0}) begin n_fail++; $display("FAIL areset_immediate: got v=%b %h expected all 0", o_valid, obs); end
    @(negedge i_clk);
    i_valid = 1'b0; i_ready = 1'b1;
    i_rst_n = 1'b1;
    #1;
    n_tests++;
    if ({o_valid, o_ready} !== 2'b01) begin n_fail++; $display("FAIL areset_release: got v/r %b expected 01", {o_valid, o_ready}); end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL areset_no_emit: got valid %b expected 0", o_valid); end
  endtask

  task automatic test_random;
    logic [6:0]  ops [12];
    logic [31:0] w;
    logic        in_x, out_x;
    exp_t        e;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
    q.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge i_clk);
      w = $urandom;
      if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 11)];
      i_instruction = w;
      i_pc    = $urandom;
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 9) < 6);
      i_flush = ($urandom_range(0, 39) == 0);
      #1;
      n_tests++;
      if (o_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rand_valid c=%0d: got %b expected %b", c, o_valid, q.size() > 0); end
      n_tests++;
      if (o_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rand_ready c=%0d: got %b expected %b", c, o_ready, q.size() < 2); end
      if (q.size() > 0) begin
        n_tests++;
        if (obs !== q[0]) begin n_fail++; $display("FAIL rand_data c=%0d: got %h expected %h", c, obs, q[0]); end
      end
      in_x  = i_valid && (q.size() < 2);
      out_x = i_ready && (q.size() > 0);
      if (i_flush) begin
        q.delete();
      end else begin
        if (out_x) void'(q.pop_front());
        if (in_x) begin
          e = ref_decode(i_instruction, i_pc);
          q.push_back(e);
        end
      end
    end
    @(negedge i_clk);
    i_valid = 1'b0; i_flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_formats();
    test_backpressure();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
